mem_bus_arbiter: RTL and testbench

Shares the single byte-wide external memory bus (mem_din/mem_dout/mem_a/mem_wr) between the instruction-fetch port and the data-access port. It arbitrates, then serialises each granted 1/2/4-byte transaction into byte cycles honouring the 2-cycle read / 1-cycle write memory timing. Sits between the IF/MA stages and the pins of the cpu top level, replacing the ad-hoc busy coupling between those stages.

---
 rtl/mem_bus_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares a byte-wide memory bus between the fetch and data ports.
// Each granted 1/2/4-byte transaction is split into byte cycles:
// 2-cycle reads (byte captured one cycle after its address), 1-cycle writes.
// Ports:
//   clk, rst (sync, active-high), rdy (low = freeze, mem_wr gated off)
//   i_req/i_addr/i_cancel -> i_done/i_rdata : word instruction fetch
//   d_req/d_we/d_width/d_addr/d_wdata -> d_done/d_rdata : data access
//   mem_din, mem_dout, mem_a, mem_wr : external byte bus; busy = not idle
// Build option: define ARB_ROUND_ROBIN_EN for alternating priority under contention.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_cancel,
  output logic              i_done,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_width,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  state_t state, state_n;
  logic [2:0] cnt;
  logic [1:0] n_last, d_n;
  logic own_i, cxl, wr_q;
  logic [31:0] acc, asm_w;
  logic [23:0] wsh;
  logic gnt_d, gnt_i, pick_d, pick_i, more, rd_end, wr_end;
`ifdef ARB_ROUND_ROBIN_EN
  logic ptr;
`endif
  // A requester whose done pulse is showing this cycle still holds req; mask it
  // so the same transaction is not granted twice.
  always_comb begin
    gnt_d = d_req & ~d_done;
    gnt_i = i_req & ~i_cancel & ~i_done;
`ifdef ARB_ROUND_ROBIN_EN
    pick_d = gnt_d & (ptr | ~gnt_i);
`else
    pick_d = gnt_d;
`endif
    pick_i = gnt_i & ~pick_d;
    d_n = d_width == 2'b00 ? 2'd0 : d_width == 2'b01 ? 2'd1 : 2'd3;
    more = cnt < {1'b0, n_last};
    rd_end = cnt == {1'b0, n_last} + 3'd1;
    wr_end = cnt == {1'b0, n_last};
    // cnt trails the address by one in RD, so the byte arriving now is index cnt-1
    asm_w = acc;
    asm_w[{cnt[1:0] - 2'd1, 3'b000} +: 8] = mem_din;
    state_n = state;
    case (state)
      IDLE:    state_n = pick_d ? (d_we ? WR : RD) : pick_i ? RD : IDLE;
      RD:      state_n = rd_end ? IDLE : RD;
      WR:      state_n = wr_end ? IDLE : WR;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      n_last <= '0;
      own_i <= 1'b0;
      cxl <= 1'b0;
      wr_q <= 1'b0;
      acc <= '0;
      wsh <= '0;
      mem_a <= '0;
      mem_dout <= '0;
      i_done <= 1'b0;
      d_done <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr <= 1'b1;
`endif
    end else if (rdy) begin
      state <= state_n;
      i_done <= 1'b0;
      d_done <= 1'b0;
      cnt <= cnt + 3'd1;
      case (state)
        IDLE: if (pick_d | pick_i) begin
          mem_a <= pick_d ? d_addr : i_addr;
          n_last <= pick_d ? d_n : 2'd3;
          own_i <= pick_i;
          wr_q <= pick_d & d_we;
          mem_dout <= d_wdata[7:0];
          wsh <= d_wdata[31:8];
          cnt <= '0;
          cxl <= 1'b0;
          acc <= '0;
`ifdef ARB_ROUND_ROBIN_EN
          if (gnt_d & gnt_i) ptr <= ~ptr;
`endif
        end
        RD: begin
          if (more) mem_a <= mem_a + ADDR_W'(1);
          if (cnt != 3'd0) acc <= asm_w;
          cxl <= cxl | i_cancel;
          if (rd_end) begin
            i_done <= own_i & ~(cxl | i_cancel);
            d_done <= ~own_i;
            if (own_i) i_rdata <= asm_w;
            else d_rdata <= asm_w;
          end
        end
        WR: if (wr_end) begin
          wr_q <= 1'b0;
          d_done <= 1'b1;
        end else begin
          mem_a <= mem_a + ADDR_W'(1);
          mem_dout <= wsh[7:0];
          wsh <= wsh >> 8;
        end
        default: ;
      endcase
    end
  end
  assign mem_wr = wr_q & rdy;
  assign busy = state != IDLE;
  // Every I/O byte address is presented once and then left behind.
  io_once: assert property (@(posedge clk) disable iff (rst)
    (rdy && state == RD && more && mem_a[17:16] == IO_HI) |=> mem_a != $past(mem_a));
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed vector table plus hand sequences for mem_bus_arbiter
module tb_mem_bus_arbiter;
  logic clk = 0, rst = 1, rdy = 1;
  logic i_req = 0, i_cancel = 0, d_req = 0, d_we = 0;
  logic [1:0] d_width = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic i_done, d_done, mem_wr, busy;
  logic [31:0] i_rdata, d_rdata, mem_a;
  logic [7:0] mem_din, mem_dout, rd_q;
  logic [7:0] mem [0:65535];
  logic bd_we = 0;
  logic [15:0] bd_a = 0;
  logic [7:0] bd_d = 0;
  int wr_cnt = 0;
  int n_chk = 0, n_fail = 0;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .i_req(i_req), .i_addr(i_addr), .i_cancel(i_cancel), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_width(d_width), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .busy(busy)
  );

  always #5 clk = ~clk;

  // registered-address memory: data for the address of cycle t appears in t+1
  assign mem_din = rd_q;
  always @(posedge clk) begin
    rd_q <= mem[mem_a[15:0]];
    if (bd_we) mem[bd_a] <= bd_d;
    if (mem_wr) begin
      mem[mem_a[15:0]] <= mem_dout;
      wr_cnt <= wr_cnt + 1;
    end
  end

  typedef struct {
    logic        is_i;
    logic        we;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bd_we = 1; bd_a = a; bd_d = d;
    @(posedge clk); #1;
    bd_we = 0;
  endtask

  // one transaction; exp holds rdata for reads, number of write cycles for writes
  task automatic run_vec(input vec_t v, input string nm);
    int lat, w0;
    logic [31:0] got;
    lat = -1; got = 0; w0 = wr_cnt;
    @(posedge clk); #1;
    if (v.is_i) begin
      i_req = 1; i_addr = v.addr;
    end else begin
      d_req = 1; d_we = v.we; d_width = v.width; d_addr = v.addr; d_wdata = v.wdata;
    end
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      @(posedge clk); @(negedge clk);
      if (v.is_i ? i_done : d_done) begin
        lat = n;
        got = v.is_i ? i_rdata : d_rdata;
      end
    end
    @(posedge clk); #1;
    i_req = 0; d_req = 0;
    chk({nm, " latency"}, lat, v.lat);
    chk({nm, v.we ? " writes" : " rdata"}, v.we ? wr_cnt - w0 : got, v.exp);
  endtask

  initial begin
    int dn, in_, dc, ic, w0;
    logic [31:0] dr, ir;
    logic b5, b6, mw7;
    logic [31:0] a7;
    logic [8:1] mw_exp;
    vecs[0]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0010, 32'h0,         32'hDF9B_5713, 6};
    vecs[1]  = '{1'b0, 1'b1, 2'd0, 32'h0003_0000, 32'h0000_0041, 32'd1,         2};
    vecs[2]  = '{1'b0, 1'b0, 2'd0, 32'h0003_0000, 32'h0,         32'h0000_0041, 3};
    vecs[3]  = '{1'b0, 1'b1, 2'd1, 32'h0000_0100, 32'hCAFE_1234, 32'd2,         3};
    vecs[4]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0,         32'h0000_1234, 6};
    vecs[5]  = '{1'b0, 1'b1, 2'd2, 32'h0000_02FE, 32'h1122_3344, 32'd4,         5};
    vecs[6]  = '{1'b0, 1'b0, 2'd2, 32'h0000_02FE, 32'h0,         32'h1122_3344, 6};
    vecs[7]  = '{1'b0, 1'b0, 2'd1, 32'h0000_0011, 32'h0,         32'h0000_9B57, 4};
    vecs[8]  = '{1'b0, 1'b0, 2'd3, 32'h0000_0010, 32'h0,         32'hDF9B_5713, 6};
    vecs[9]  = '{1'b0, 1'b1, 2'd2, 32'hFFFF_FFFE, 32'hA1B2_C3D4, 32'd4,         5};
    vecs[10] = '{1'b0, 1'b0, 2'd1, 32'h0000_0000, 32'h0,         32'h0000_A1B2, 4};
    vecs[11] = '{1'b1, 1'b0, 2'd2, 32'hFFFF_FFFF, 32'h0,         32'h00A1_B2C3, 6};

    poke(16'h0010, 8'h13); poke(16'h0011, 8'h57); poke(16'h0012, 8'h9B); poke(16'h0013, 8'hDF);
    poke(16'h0200, 8'hAA); poke(16'h0201, 8'hBB);
    poke(16'h0102, 8'h00); poke(16'h0103, 8'h00); poke(16'h0002, 8'h00);

    @(negedge clk);
    chk("reset busy", {31'b0, busy}, 0);
    chk("reset dones", {30'b0, i_done, d_done}, 0);
    chk("reset mem_wr", {31'b0, mem_wr}, 0);
    chk("reset mem_a", mem_a, 0);
    chk("reset rdata", i_rdata | d_rdata | {24'b0, mem_dout}, 0);
    @(posedge clk); #1;
    rst = 0;

    // word fetch address trace
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h10;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); @(negedge clk);
      if (n <= 4) begin
        chk($sformatf("fetch mem_a T+%0d", n), mem_a, 32'h10 + n - 1);
        chk($sformatf("fetch mem_wr T+%0d", n), {31'b0, mem_wr}, 0);
      end
      if (n == 6) chk("fetch i_done T+6", {31'b0, i_done}, 1);
    end
    @(posedge clk); #1;
    i_req = 0;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // contention: data half read wins, fetch follows
    dn = -1; in_ = -1; dc = 0; ic = 0; dr = 0; ir = 0;
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h10;
    d_req = 1; d_we = 0; d_width = 2'd1; d_addr = 32'h200;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk); #1;
      if (dn > 0) d_req = 0;
      if (in_ > 0) i_req = 0;
      @(negedge clk);
      if (d_done) begin dc++; if (dn < 0) begin dn = n; dr = d_rdata; end end
      if (i_done) begin ic++; if (in_ < 0) begin in_ = n; ir = i_rdata; end end
    end
    chk("contend d_done cycle", dn, 4);
    chk("contend d_rdata", dr, 32'h0000_BBAA);
    chk("contend i_done cycle", in_, 10);
    chk("contend i_rdata", ir, 32'hDF9B_5713);
    chk("contend pulse counts", {dc[15:0], ic[15:0]}, {16'd1, 16'd1});

    // cancel mid-fetch, queued data write granted when bus frees
    dn = -1; ic = 0; b5 = 0; b6 = 1; mw7 = 0; a7 = 0;
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h10;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin d_req = 1; d_we = 1; d_width = 0; d_addr = 32'h500; d_wdata = 32'h99; end
      if (n == 3) begin i_cancel = 1; i_req = 0; end
      if (n == 4) i_cancel = 0;
      if (dn > 0) d_req = 0;
      @(negedge clk);
      if (i_done) ic++;
      if (d_done && dn < 0) dn = n;
      if (n == 5) b5 = busy;
      if (n == 6) b6 = busy;
      if (n == 7) begin mw7 = mem_wr; a7 = mem_a; end
    end
    chk("cancel no i_done", ic, 0);
    chk("cancel busy T+5", {31'b0, b5}, 1);
    chk("cancel busy T+6", {31'b0, b6}, 0);
    chk("cancel d write T+7", {31'b0, mw7}, 1);
    chk("cancel d addr T+7", a7, 32'h500);
    chk("cancel d_done cycle", dn, 8);

    // freeze for three cycles in a word write
    mw_exp = 8'b0111_0001;
    dn = -1; w0 = wr_cnt;
    @(posedge clk); #1;
    d_req = 1; d_we = 1; d_width = 2'd2; d_addr = 32'h400; d_wdata = 32'h5566_7788;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (n == 2) rdy = 0;
      if (n == 5) rdy = 1;
      if (dn > 0) d_req = 0;
      @(negedge clk);
      if (d_done && dn < 0) dn = n;
      if (n <= 8) chk($sformatf("freeze mem_wr T+%0d", n), {31'b0, mem_wr}, {31'b0, mw_exp[n]});
      if (n == 1) chk("freeze mem_a T+1", mem_a, 32'h400);
      if (n >= 5 && n <= 7) chk($sformatf("freeze mem_a T+%0d", n), mem_a, 32'h401 + n - 5);
    end
    chk("freeze d_done cycle", dn, 8);
    chk("freeze write count", wr_cnt - w0, 4);
    run_vec('{1'b0, 1'b0, 2'd2, 32'h400, 32'h0, 32'h5566_7788, 6}, "freeze readback");

    // reset in the middle of a word write
    dn = -1; w0 = wr_cnt;
    @(posedge clk); #1;
    d_req = 1; d_we = 1; d_width = 2'd2; d_addr = 32'h600; d_wdata = 32'hDEAD_BEEF;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (n == 2) rst = 1;
      if (n == 3) begin rst = 0; d_req = 0; end
      @(negedge clk);
      if (d_done && dn < 0) dn = n;
      if (n == 3) begin
        chk("reset abort mem_wr", {31'b0, mem_wr}, 0);
        chk("reset abort busy", {31'b0, busy}, 0);
        chk("reset abort mem_a", mem_a, 0);
        chk("reset abort mem_dout", {24'b0, mem_dout}, 0);
      end
    end
    chk("reset abort no d_done", dn, -1);
    chk("reset abort writes", wr_cnt - w0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
